mesi_cbus_snoop_agent: RTL

//  Cache-side responder for the coherence bus driven by mesi_isc: one instance per CPU port.

---
 rtl/mesi_cbus_snoop_agent.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mesi_cbus_snoop_agent.sv
// mesi_cbus_snoop_agent
//   Cache-side responder for the mesi_isc coherence bus (one per CPU port).
//   Accepts snoop/enable commands, tracks a direct-mapped MESI line-state
//   table, pulses writeback requests for modified lines and closes the
//   cbus handshake with a one-cycle ack.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cbus_cmd_i        0 NOP, 1 WR_SNOOP, 2 RD_SNOOP, 3 EN_WR, 4 EN_RD (5-7 = NOP)
//   cbus_addr_i       line address, valid while a command is presented
//   cbus_ack_o        one-cycle ack closing the current command
//   wb_req_o          one-cycle writeback request pulse
//   wb_addr_o         writeback line address, valid with wb_req_o
//   cpu_en_wr_o       one-cycle write grant (EN_WR), coincident with ack
//   cpu_en_rd_o       one-cycle read grant (EN_RD), coincident with ack
//   dbg_idx_i         debug table index
//   dbg_state_o       combinational line state at dbg_idx_i (0 I, 1 S, 2 E, 3 M)
//
// Optional build macro
//   MESI_SNOOP_STATS_EN  adds snoop_hit_cnt_o[15:0] and wb_cnt_o[15:0],
//                        saturating event counters cleared by rst.
module mesi_cbus_snoop_agent #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned OFFSET_W   = 2,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cbus_cmd_i,
  input  logic [ADDR_W-1:0] cbus_addr_i,
  output logic              cbus_ack_o,
  output logic              wb_req_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic              cpu_en_wr_o,
  output logic              cpu_en_rd_o,
  input  logic [IDX_W-1:0]  dbg_idx_i,
  output logic [1:0]        dbg_state_o
`ifdef MESI_SNOOP_STATS_EN
  ,
  output logic [15:0]       snoop_hit_cnt_o,
  output logic [15:0]       wb_cnt_o
`endif
);

  localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - IDX_W;
  localparam int unsigned LINES   = 1 << IDX_W;
  localparam int unsigned WBCNT_W = 4;

  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, ACK, WAIT_NOP} fsm_t;

  fsm_t                 fsm_q;
  logic [2:0]           cmd_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WBCNT_W-1:0]   wb_left_q;
  logic                 upd_we_q;
  mesi_t                upd_st_q;

  logic [TAG_W-1:0]     tag_q [LINES];
  mesi_t                st_q  [LINES];

  logic                 cmd_valid_c;
  logic [IDX_W-1:0]     idx_c;
  logic [TAG_W-1:0]     tag_c;
  logic [TAG_W-1:0]     cur_tag_c;
  mesi_t                cur_st_c;
  logic                 hit_c;
  logic                 is_snoop_c;
  logic                 need_wb_c;
  logic [ADDR_W-1:0]    wb_addr_c;
  logic                 upd_we_c;
  mesi_t                upd_st_c;

  // Command decode and lookup of the captured address
  assign cmd_valid_c = (cbus_cmd_i >= 3'd1) && (cbus_cmd_i <= 3'd4);
  assign idx_c       = addr_q[OFFSET_W+IDX_W-1:OFFSET_W];
  assign tag_c       = addr_q[ADDR_W-1:OFFSET_W+IDX_W];
  assign cur_tag_c   = tag_q[idx_c];
  assign cur_st_c    = st_q[idx_c];
  assign hit_c       = (cur_tag_c == tag_c) && (cur_st_c != ST_I);
  assign is_snoop_c  = (cmd_q == CMD_WR_SNOOP) || (cmd_q == CMD_RD_SNOOP);

  // Snoops write back the hit M line; enables write back an evicted M victim
  assign need_wb_c = is_snoop_c ? (hit_c && (cur_st_c == ST_M))
                                : ((cur_st_c == ST_M) && (cur_tag_c != tag_c));
  assign wb_addr_c = is_snoop_c ? addr_q : {cur_tag_c, idx_c, OFFSET_W'(0)};

  // Next line state, committed when the ack is issued
  always_comb begin
    upd_we_c = 1'b0;
    upd_st_c = ST_I;
    case (cmd_q)
      CMD_WR_SNOOP: begin upd_we_c = hit_c; upd_st_c = ST_I; end
      CMD_RD_SNOOP: begin upd_we_c = hit_c; upd_st_c = ST_S; end
      CMD_EN_WR:    begin upd_we_c = 1'b1;  upd_st_c = ST_M; end
      CMD_EN_RD:    begin upd_we_c = 1'b1;  upd_st_c = ST_S; end
      default:      begin upd_we_c = 1'b0;  upd_st_c = ST_I; end
    endcase
  end

  assign dbg_state_o = st_q[dbg_idx_i];

  // Handshake FSM, table and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cmd_q       <= 3'd0;
      addr_q      <= '0;
      wb_left_q   <= '0;
      upd_we_q    <= 1'b0;
      upd_st_q    <= ST_I;
      cbus_ack_o  <= 1'b0;
      wb_req_o    <= 1'b0;
      wb_addr_o   <= '0;
      cpu_en_wr_o <= 1'b0;
      cpu_en_rd_o <= 1'b0;
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_q[IDX_W'(i)] <= '0;
        st_q[IDX_W'(i)]  <= ST_I;
      end
`ifdef MESI_SNOOP_STATS_EN
      snoop_hit_cnt_o <= 16'd0;
      wb_cnt_o        <= 16'd0;
`endif
    end else begin
      cbus_ack_o  <= 1'b0;
      wb_req_o    <= 1'b0;
      cpu_en_wr_o <= 1'b0;
      cpu_en_rd_o <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (cmd_valid_c) begin
            cmd_q  <= cbus_cmd_i;
            addr_q <= cbus_addr_i;
            fsm_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          upd_we_q <= upd_we_c;
          upd_st_q <= upd_st_c;
`ifdef MESI_SNOOP_STATS_EN
          if (is_snoop_c && hit_c && (snoop_hit_cnt_o != 16'hFFFF))
            snoop_hit_cnt_o <= snoop_hit_cnt_o + 16'd1;
          if (need_wb_c && (wb_cnt_o != 16'hFFFF))
            wb_cnt_o <= wb_cnt_o + 16'd1;
`endif
          if (need_wb_c) begin
            fsm_q     <= WB;
            wb_req_o  <= 1'b1;
            wb_addr_o <= wb_addr_c;
            wb_left_q <= WBCNT_W'(WB_LATENCY - 1);
          end else begin
            fsm_q       <= ACK;
            cbus_ack_o  <= 1'b1;
            cpu_en_wr_o <= (cmd_q == CMD_EN_WR);
            cpu_en_rd_o <= (cmd_q == CMD_EN_RD);
          end
        end
        WB: begin
          if (wb_left_q == '0) begin
            fsm_q       <= ACK;
            cbus_ack_o  <= 1'b1;
            cpu_en_wr_o <= (cmd_q == CMD_EN_WR);
            cpu_en_rd_o <= (cmd_q == CMD_EN_RD);
          end else begin
            wb_left_q <= wb_left_q - WBCNT_W'(1);
          end
        end
        ACK: begin
          if (upd_we_q) begin
            tag_q[idx_c] <= tag_c;
            st_q[idx_c]  <= upd_st_q;
          end
          fsm_q <= WAIT_NOP;
        end
        WAIT_NOP: begin
          if (!cmd_valid_c) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule
